// File: rtl/seq_pkg.sv
// Shared constants for the fetch/execute control sequencer: opcode map,
// ALU operation encodings, FSM state and jump-type encodings.
package seq_pkg;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDI  = 4'h1;
  localparam logic [3:0] OPC_MOV  = 4'h2;
  localparam logic [3:0] OPC_ADD  = 4'h3;
  localparam logic [3:0] OPC_SUB  = 4'h4;
  localparam logic [3:0] OPC_ADDI = 4'h5;
  localparam logic [3:0] OPC_AND  = 4'h6;
  localparam logic [3:0] OPC_OR   = 4'h7;
  localparam logic [3:0] OPC_XOR  = 4'h8;
  localparam logic [3:0] OPC_JMP  = 4'h9;
  localparam logic [3:0] OPC_JZ   = 4'hA;
  localparam logic [3:0] OPC_JNZ  = 4'hB;
  localparam logic [3:0] OPC_CALL = 4'hC;
  localparam logic [3:0] OPC_RET  = 4'hD;
  localparam logic [3:0] OPC_HLT  = 4'hF;

  localparam logic [3:0] ALU_PASS = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    JT_NONE = 3'd0,
    JT_JMP  = 3'd1,
    JT_JZ   = 3'd2,
    JT_JNZ  = 3'd3,
    JT_CALL = 3'd4,
    JT_RET  = 3'd5,
    JT_HALT = 3'd6
  } jump_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decode: opcode -> datapath controls and jump type.
// SEQ_CALL_STACK_EN turns 0xC/0xD into CALL/RET instead of reserved opcodes.
module seq_decode
  import seq_pkg::*;
#(
  parameter int OP_WIDTH = 4
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output logic                sel,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic                ce_acc,
  output logic                ce_r0,
  output jump_t               jump,
  output logic                illegal
);

  logic [3:0] opc;
  assign opc = 4'(opcode);

  always_comb begin
    sel     = 1'b0;
    alu_op  = OP_WIDTH'(ALU_PASS);
    ce_acc  = 1'b0;
    ce_r0   = 1'b0;
    jump    = JT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_NOP:  ;
      OPC_LDI:  begin sel = 1'b1; ce_acc = 1'b1; end
      OPC_MOV:  ce_r0 = 1'b1;
      OPC_ADD:  begin alu_op = OP_WIDTH'(ALU_ADD); ce_acc = 1'b1; end
      OPC_SUB:  begin alu_op = OP_WIDTH'(ALU_SUB); ce_acc = 1'b1; end
      OPC_ADDI: begin sel = 1'b1; alu_op = OP_WIDTH'(ALU_ADD); ce_acc = 1'b1; end
      OPC_AND:  begin alu_op = OP_WIDTH'(ALU_AND); ce_acc = 1'b1; end
      OPC_OR:   begin alu_op = OP_WIDTH'(ALU_OR);  ce_acc = 1'b1; end
      OPC_XOR:  begin alu_op = OP_WIDTH'(ALU_XOR); ce_acc = 1'b1; end
      OPC_JMP:  jump = JT_JMP;
      OPC_JZ:   jump = JT_JZ;
      OPC_JNZ:  jump = JT_JNZ;
`ifdef SEQ_CALL_STACK_EN
      OPC_CALL: jump = JT_CALL;
      OPC_RET:  jump = JT_RET;
`else
      OPC_CALL: illegal = 1'b1;
      OPC_RET:  illegal = 1'b1;
`endif
      OPC_HLT:  jump = JT_HALT;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute controller for the 8-bit accumulator datapath: owns PC and IR.
// Optional return stack for CALL/RET is enabled by defining SEQ_CALL_STACK_EN.
module control_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OP_WIDTH    = 4,
  parameter int PC_WIDTH    = 4,
  parameter int INSTR_WIDTH = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RUN,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   MEM_REQ,
  input  logic                   MEM_ACK,
  input  logic [INSTR_WIDTH-1:0] INSTR,
  output logic [DATA_WIDTH-1:0]  IMM,
  output logic                   SEL,
  output logic [OP_WIDTH-1:0]    ALU_OP,
  output logic                   CE_ACC,
  output logic                   CE_R0,
  input  logic                   ACC_ZERO,
  output logic                   HALTED,
  output logic                   ILLEGAL
);

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic [PC_WIDTH-1:0]    pc_nxt;
  logic [PC_WIDTH-1:0]    imm_pc;
  logic [PC_WIDTH-1:0]    pop_pc;
  logic [INSTR_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0]  imm;
  logic                   in_exec;
  logic                   stack_fault;

  logic                   dec_sel;
  logic [OP_WIDTH-1:0]    dec_alu_op;
  logic                   dec_ce_acc;
  logic                   dec_ce_r0;
  jump_t                  dec_jump;
  logic                   dec_illegal;

  assign imm     = ir[DATA_WIDTH-1:0];
  assign imm_pc  = imm[PC_WIDTH-1:0];
  assign pc_inc  = pc + PC_WIDTH'(1);
  assign in_exec = (state == ST_EXEC) && !RST;

  seq_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
    .opcode  (ir[INSTR_WIDTH-1 -: OP_WIDTH]),
    .sel     (dec_sel),
    .alu_op  (dec_alu_op),
    .ce_acc  (dec_ce_acc),
    .ce_r0   (dec_ce_r0),
    .jump    (dec_jump),
    .illegal (dec_illegal)
  );

`ifdef SEQ_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]     sp;
  logic                stack_full;
  logic                stack_empty;
  logic                do_push;
  logic                do_pop;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign stack_fault = in_exec && (((dec_jump == JT_CALL) && stack_full) ||
                                   ((dec_jump == JT_RET) && stack_empty));
  assign do_push     = in_exec && (dec_jump == JT_CALL) && !stack_full;
  assign do_pop      = in_exec && (dec_jump == JT_RET) && !stack_empty;
  assign pop_pc      = stack[IDX_W'(sp - SP_W'(1))];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Entry contents need no reset: sp alone defines which entries are live.
  always_ff @(posedge CLK) begin
    if (do_push) stack[IDX_W'(sp)] <= pc_inc;
  end
`else
  assign stack_fault = 1'b0;
  assign pop_pc      = '0;
`endif

  always_comb begin
    pc_nxt = pc_inc;
    case (dec_jump)
      JT_JMP:  pc_nxt = imm_pc;
      JT_JZ:   if (ACC_ZERO) pc_nxt = imm_pc;
      JT_JNZ:  if (!ACC_ZERO) pc_nxt = imm_pc;
      JT_CALL: if (!stack_fault) pc_nxt = imm_pc;
      JT_RET:  if (!stack_fault) pc_nxt = pop_pc;
      JT_HALT: pc_nxt = pc;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH: if (RUN && MEM_ACK) begin
          ir    <= INSTR;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          pc    <= pc_nxt;
          state <= (dec_jump == JT_HALT) ? ST_HALT : ST_FETCH;
        end
        ST_HALT: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Every output is forced to its reset value while RST is high, so a reset
  // landing on an EXEC cycle cannot leak a load enable into the datapath.
  assign PC      = RST ? '0 : pc;
  assign IMM     = RST ? '0 : imm;
  assign MEM_REQ = (state == ST_FETCH) && RUN && !RST;
  assign SEL     = in_exec && dec_sel;
  assign ALU_OP  = in_exec ? dec_alu_op : OP_WIDTH'(ALU_PASS);
  assign CE_ACC  = in_exec && dec_ce_acc;
  assign CE_R0   = in_exec && dec_ce_r0;
  assign ILLEGAL = in_exec && (dec_illegal || stack_fault);
  assign HALTED  = (state == ST_HALT) && !RST;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer; CALL/RET vectors follow SEQ_CALL_STACK_EN.
module tb_control_sequencer;
  import seq_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RUN = 1'b1;
  logic        MEM_ACK = 1'b1;
  logic        ACC_ZERO = 1'b0;
  logic [3:0]  PC;
  logic        MEM_REQ;
  logic [11:0] INSTR;
  logic [7:0]  IMM;
  logic        SEL;
  logic [3:0]  ALU_OP;
  logic        CE_ACC;
  logic        CE_R0;
  logic        HALTED;
  logic        ILLEGAL;

  logic [11:0] mem [16];
  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  assign INSTR = mem[PC];

  always #5 CLK = ~CLK;

  control_sequencer #(
    .DATA_WIDTH (8),
    .OP_WIDTH   (4),
    .PC_WIDTH   (4),
    .INSTR_WIDTH(12),
    .STACK_DEPTH(4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .RUN     (RUN),
    .PC      (PC),
    .MEM_REQ (MEM_REQ),
    .MEM_ACK (MEM_ACK),
    .INSTR   (INSTR),
    .IMM     (IMM),
    .SEL     (SEL),
    .ALU_OP  (ALU_OP),
    .CE_ACC  (CE_ACC),
    .CE_R0   (CE_R0),
    .ACC_ZERO(ACC_ZERO),
    .HALTED  (HALTED),
    .ILLEGAL (ILLEGAL)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    #1;
  endtask

  // One instruction at address 0; report the fetch address that follows it.
  task automatic run_first(input string tag, input logic [11:0] instr,
                           input logic z, input logic [3:0] exp_pc);
    clear_mem();
    mem[0]   = instr;
    ACC_ZERO = z;
    do_reset();
    step(2);
    check(tag, PC, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_mem();

    // Reset values while RST is held
    step(2);
    check("rst_pc", PC, 0);
    check("rst_req", MEM_REQ, 0);
    check("rst_halted", HALTED, 0);
    check("rst_alu", ALU_OP, ALU_PASS);
    check("rst_ce_acc", CE_ACC, 0);
    check("rst_sel", SEL, 0);

    // Program: LDI 0x05, MOV, ADDI 0x03, HLT with ACK tied high
    mem[0] = 12'h105;
    mem[1] = 12'h200;
    mem[2] = 12'h503;
    mem[3] = 12'hF00;
    do_reset();
    check("p1_fetch0_req", MEM_REQ, 1);
    check("p1_fetch0_pc", PC, 0);
    check("p1_fetch0_ce", CE_ACC, 0);
    step();
    check("p1_ldi_sel", SEL, 1);
    check("p1_ldi_alu", ALU_OP, ALU_PASS);
    check("p1_ldi_ce", CE_ACC, 1);
    check("p1_ldi_imm", IMM, 8'h05);
    check("p1_ldi_req", MEM_REQ, 0);
    step();
    check("p1_fetch1_pc", PC, 1);
    step();
    check("p1_mov_r0", CE_R0, 1);
    check("p1_mov_acc", CE_ACC, 0);
    step();
    check("p1_fetch2_pc", PC, 2);
    step();
    check("p1_addi_sel", SEL, 1);
    check("p1_addi_alu", ALU_OP, ALU_ADD);
    check("p1_addi_ce", CE_ACC, 1);
    step(2);
    check("p1_hlt_exec_halted", HALTED, 0);
    step();
    check("p1_halted", HALTED, 1);
    check("p1_halt_pc", PC, 3);
    check("p1_halt_req", MEM_REQ, 0);
    step(3);
    check("p1_halt_stay", HALTED, 1);
    check("p1_halt_pc_stay", PC, 3);

    // Delayed ack: request held with PC stable, EXEC after the ack cycle
    clear_mem();
    mem[0]  = 12'h300;
    MEM_ACK = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("ack_wait_req", MEM_REQ, 1);
      check("ack_wait_pc", PC, 0);
      check("ack_wait_ce", {CE_ACC, CE_R0}, 0);
      step();
    end
    MEM_ACK = 1'b1;
    #1;
    check("ack_cycle_req", MEM_REQ, 1);
    check("ack_cycle_ce", CE_ACC, 0);
    step();
    check("ack_add_ce", CE_ACC, 1);
    check("ack_add_alu", ALU_OP, ALU_ADD);
    check("ack_add_sel", SEL, 0);

    // RUN low drops the request and ignores the ack
    clear_mem();
    mem[0]  = 12'h105;
    MEM_ACK = 1'b0;
    do_reset();
    check("run_req_on", MEM_REQ, 1);
    RUN = 1'b0;
    #1;
    check("run_req_drop", MEM_REQ, 0);
    MEM_ACK = 1'b1;
    step(2);
    check("run_off_req", MEM_REQ, 0);
    check("run_off_pc", PC, 0);
    check("run_off_ce", CE_ACC, 0);
    RUN = 1'b1;
    #1;
    check("run_back_req", MEM_REQ, 1);
    step();
    check("run_back_exec", CE_ACC, 1);

    // Conditional jumps and JMP with upper immediate bits ignored
    run_first("jz_taken", 12'hA07, 1'b1, 4'h7);
    run_first("jz_not_taken", 12'hA07, 1'b0, 4'h1);
    run_first("jnz_not_taken", 12'hB07, 1'b1, 4'h1);
    run_first("jnz_taken", 12'hB07, 1'b0, 4'h7);
    run_first("jmp_a5", 12'h9A5, 1'b0, 4'h5);
    ACC_ZERO = 1'b0;

    // PC wrap from 0xF to 0x0
    clear_mem();
    mem[0]  = 12'h90F;
    mem[15] = 12'h000;
    do_reset();
    step(2);
    check("wrap_at_f", PC, 4'hF);
    step(2);
    check("wrap_to_0", PC, 4'h0);

    // Reset during EXEC suppresses CE and returns to FETCH at PC 0
    clear_mem();
    mem[0] = 12'h000;
    mem[1] = 12'h300;
    do_reset();
    step(3);
    check("rx_pre_ce", CE_ACC, 1);
    RST = 1'b1;
    #1;
    check("rx_ce_gated", CE_ACC, 0);
    check("rx_alu_gated", ALU_OP, ALU_PASS);
    step();
    check("rx_pc", PC, 0);
    check("rx_req", MEM_REQ, 0);
    check("rx_outs", {SEL, CE_ACC, CE_R0, HALTED, ILLEGAL}, 0);
    RST = 1'b0;
    #1;
    check("rx_fetch_req", MEM_REQ, 1);
    check("rx_fetch_pc", PC, 0);

    // Reserved opcode 0xE: one-cycle ILLEGAL, then PC+1
    clear_mem();
    mem[0] = 12'hE00;
    do_reset();
    step();
    check("rsvd_illegal", ILLEGAL, 1);
    check("rsvd_ce", CE_ACC, 0);
    step();
    check("rsvd_illegal_drop", ILLEGAL, 0);
    check("rsvd_pc", PC, 1);

`ifdef SEQ_CALL_STACK_EN
    // Five nested CALLs on a 4-deep stack, then RET
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 12'hC01 + 12'(i);
    mem[5] = 12'hD00;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("call_ok_illegal", ILLEGAL, 0);
      step();
      check("call_target", PC, i + 1);
    end
    step();
    check("call_overflow_illegal", ILLEGAL, 1);
    step();
    check("call_overflow_pc", PC, 5);
    step();
    check("ret_ok_illegal", ILLEGAL, 0);
    step();
    check("ret_pc", PC, 4);

    clear_mem();
    mem[0] = 12'hD00;
    do_reset();
    step();
    check("ret_empty_illegal", ILLEGAL, 1);
    step();
    check("ret_empty_pc", PC, 1);
`else
    clear_mem();
    mem[0] = 12'hC03;
    do_reset();
    step();
    check("call_rsvd_illegal", ILLEGAL, 1);
    step();
    check("call_rsvd_pc", PC, 1);

    clear_mem();
    mem[0] = 12'hD00;
    do_reset();
    step();
    check("ret_rsvd_illegal", ILLEGAL, 1);
    step();
    check("ret_rsvd_pc", PC, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle fetch/execute controller for the 8-bit accumulator datapath (ACC, R0, ALU, immediate mux). It replaces the free-running program counter and the purely combinational decode.
- Owns the PC and the instruction register.
- Fetches 12-bit instructions (opcode[11:8], immediate[7:0]) over a req/ack handshake.
- Drives the mux select, ACC/R0 clock enables and ALU op.
- Supports conditional jumps on an ACC-zero flag, and halt.

Parameters:
DATA_WIDTH, 8, immediate/data width
OP_WIDTH, 4, opcode and ALU-op width
PC_WIDTH, 4, program counter width (program space 2^PC_WIDTH words)
INSTR_WIDTH, 12, instruction width (OP_WIDTH + DATA_WIDTH)
STACK_DEPTH, 4, return-stack entries (used only with SEQ_CALL_STACK_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
RUN  in  1  fetch enable; no new fetch starts while 0
PC  out  PC_WIDTH  fetch address
MEM_REQ  out  1  fetch request
MEM_ACK  in  1  fetch data valid; may be high in the same cycle as MEM_REQ
INSTR  in  INSTR_WIDTH  fetched word, sampled when MEM_REQ&MEM_ACK
IMM  out  DATA_WIDTH  IR[7:0] to the mux IN1
SEL  out  1  mux select (1 = immediate)
ALU_OP  out  OP_WIDTH  ALU operation
CE_ACC  out  1  ACC load enable
CE_R0  out  1  R0 load enable (R0 <= ACC)
ACC_ZERO  in  1  ACC == 0, from datapath
HALTED  out  1  high in HALT state
ILLEGAL  out  1  one-cycle pulse on a reserved opcode or stack fault

Behaviour:
- Reset (RST=1 at a clock edge), mandatory and overriding everything:
  - PC=0, IR=0, state=FETCH, return stack emptied.
  - MEM_REQ, SEL, CE_ACC, CE_R0, HALTED, ILLEGAL = 0; ALU_OP=ALU_PASS.
  - All outputs are gated low by RST in the same cycle, so reset during EXEC suppresses that cycle's CE pulses.
- States: FETCH, EXEC, HALT.
- FETCH:
  - MEM_REQ=RUN. PC and MEM_REQ are held stable until ack.
  - On MEM_REQ&MEM_ACK: IR<=INSTR, go to EXEC.
  - All CE/ILLEGAL outputs are 0 in FETCH.
- EXEC (exactly 1 cycle): control outputs decode combinationally from IR; PC updates; go to FETCH (or HALT).
  - Minimum 2 cycles per instruction with MEM_ACK tied high.
- Opcode map:
  - 0x0 NOP
  - 0x1 LDI: SEL=1, PASS, CE_ACC
  - 0x2 MOV: CE_R0
  - 0x3 ADD: SEL=0, ADD, CE_ACC
  - 0x4 SUB: SEL=0, SUB, CE_ACC
  - 0x5 ADDI: SEL=1, ADD, CE_ACC
  - 0x6 AND, 0x7 OR, 0x8 XOR: SEL=0, CE_ACC
  - 0x9 JMP
  - 0xA JZ
  - 0xB JNZ
  - 0xC/0xD reserved (CALL/RET with macro)
  - 0xE reserved
  - 0xF HLT
- PC update:
  - Default PC+1, wrapping mod 2^PC_WIDTH (0xF -> 0x0).
  - Jump targets are IMM[PC_WIDTH-1:0]; upper IMM bits are ignored.
  - JZ/JNZ sample ACC_ZERO during the EXEC cycle. This sees the result of the previous instruction, because ACC updates at the end of that instruction's EXEC.
- Reserved opcode: ILLEGAL=1 for the EXEC cycle, otherwise NOP, PC+1.
- HLT: PC is not advanced; go to HALT. HALTED=1, no MEM_REQ; only RST exits.
- RUN=0 mid-handshake: an outstanding MEM_REQ drops; the ack is ignored; PC is unchanged.
- ALU_OP encodings are the shared package constants (PASS, ADD, SUB, AND, OR, XOR).

Optional Feature:
SEQ_CALL_STACK_EN
- Defined:
  - 0xC CALL pushes PC+1 (wrapped) onto a STACK_DEPTH-entry LIFO and jumps to IMM.
  - 0xD RET pops into PC.
  - Push on a full stack or pop on an empty stack: ILLEGAL pulse, no stack change, NOP with PC+1.
  - Reset empties the stack.
- Undefined: no stack logic; 0xC/0xD behave as reserved opcodes (ILLEGAL pulse, PC+1).

Decomposition:
- Package seq_pkg holds:
  - opcode constants (OPC_NOP..OPC_HLT)
  - ALU op constants (ALU_PASS..ALU_XOR)
  - FSM state encoding
- One combinational sub-module, seq_decode: IR opcode -> SEL/ALU_OP/CE_ACC/CE_R0/jump-type/illegal.
- The return stack stays inline under the macro.

Test Plan:
1. ACK tied 1; program LDI 0x05, MOV, ADDI 0x03, HLT. First EXEC is at cycle 2 after reset release, with SEL=1, ALU_OP=PASS, CE_ACC=1, IMM=0x05. HALTED rises after 8 cycles with PC frozen at 3.
2. MEM_ACK delayed 3 cycles -> MEM_REQ held 4 cycles with PC constant and CE_ACC=CE_R0=0 throughout; EXEC follows the ack cycle.
3. JZ 0x7 with ACC_ZERO=1 -> next PC=0x7. Same with ACC_ZERO=0 -> PC+1. JNZ gives the inverse results.
4. NOP at PC=0xF -> next fetch address 0x0. JMP 0xA5 -> PC=0x5.
5. RST high during the EXEC of ADD -> CE_ACC=0 in that cycle. Next cycle: PC=0, FETCH, all outputs at reset values.
6. Opcode 0xE -> one-cycle ILLEGAL, PC+1. With SEQ_CALL_STACK_EN, 5 nested CALLs: 5th gives ILLEGAL with PC+1; RET on an empty stack gives ILLEGAL.
